yarp_lsu: RTL

Load/store unit for the YARP core. It sits directly downstream of the instruction control unit's memory-stage outputs and turns one data request (address from the ALU, store data from rs2) into a single request/grant/response transaction on the data-memory bus. While a transaction is in flight it raises `lsu_busy_o`, which drives the control unit's `control_d_cache_busy_in` stall input. For loads it returns aligned, sign- or zero-extended write-back data.

---
 rtl/yarp_pkg.sv | 30 +++
 rtl/yarp_lsu_align.sv | 52 +++++
 rtl/yarp_lsu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/yarp_pkg.sv
// Shared types for the YARP core: memory access sizes and LSU states.
// Byte/Half/Word encoding matches the control unit's data_byte output.
package yarp_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_access_size_t;

   typedef enum logic [1:0] {
      LSU_IDLE     = 2'd0,
      LSU_REQ      = 2'd1,
      LSU_WAIT_RSP = 2'd2,
      LSU_DONE     = 2'd3
   } lsu_state_t;

   // The illegal size encoding falls through to the Word rule.
   function automatic logic is_misaligned(input mem_access_size_t size,
                                          input logic [1:0] offset);
      case (size)
         MEM_BYTE: is_misaligned = 1'b0;
         MEM_HALF: is_misaligned = offset[0];
         default:  is_misaligned = (offset != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/yarp_lsu_align.sv
// Lane logic for the LSU: store byte enables and lane replication,
// plus load lane extraction with sign or zero extension.
module yarp_lsu_align
   import yarp_pkg::*;
(
   input  mem_access_size_t st_size,
   input  logic [1:0]       st_offset,
   input  logic [31:0]      st_data,
   output logic [3:0]       be,
   output logic [31:0]      wdata,
   input  mem_access_size_t ld_size,
   input  logic [1:0]       ld_offset,
   input  logic             ld_zext,
   input  logic [31:0]      rdata,
   output logic [31:0]      ld_data
);

   logic [31:0] shifted_s;

   assign shifted_s = rdata >> {ld_offset, 3'b000};

   // store-side byte enables and replicated write data
   always_comb begin
      be    = 4'b1111;
      wdata = st_data;
      case (st_size)
         MEM_BYTE: begin
            be    = 4'b0001 << st_offset;
            wdata = {4{st_data[7:0]}};
         end
         MEM_HALF: begin
            be    = 4'b0011 << st_offset;
            wdata = {2{st_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = st_data;
         end
      endcase
   end

   // load-side lane extraction and extension
   always_comb begin
      ld_data = shifted_s;
      case (ld_size)
         MEM_BYTE: ld_data = {{24{~ld_zext & shifted_s[7]}},  shifted_s[7:0]};
         MEM_HALF: ld_data = {{16{~ld_zext & shifted_s[15]}}, shifted_s[15:0]};
         default:  ld_data = shifted_s;
      endcase
   end

endmodule

// File: rtl/yarp_lsu.sv
// YARP load/store unit: one request/grant/response bus transaction per
// memory-stage request, with misalignment drop and a response timeout.
module yarp_lsu
   import yarp_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        data_req_i,
   input  logic        data_wr_i,
   input  logic [1:0]  data_byte_i,
   input  logic        zero_extnd_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wr_data_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_wr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        lsu_busy_o,
   output logic [31:0] rd_data_o,
   output logic        rd_valid_o,
   output logic        misalign_o,
   output logic        timeout_o
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_t       state_r, state_nxt_s;
   mem_access_size_t req_size_s, size_r;
   logic [1:0]       offset_r;
   logic             wr_r, zext_r;
   logic [7:0]       cnt_r;

   logic             mem_req_r, mem_wr_r;
   logic [31:0]      mem_addr_r, mem_wdata_r;
   logic [3:0]       mem_be_r;
   logic [31:0]      rd_data_r;
   logic             rd_valid_r, misalign_r, timeout_r;

   logic [3:0]       st_be_s;
   logic [31:0]      st_wdata_s, ld_data_s;
   logic             capture_s, misalign_s, timeout_hit_s;
   logic             set_misalign_s, set_timeout_s, ld_done_s;

   assign req_size_s    = mem_access_size_t'(data_byte_i);
   assign capture_s     = (state_r == LSU_IDLE) && data_req_i;
   assign misalign_s    = is_misaligned(req_size_s, addr_i[1:0]);
   // >= rather than == so a load granted on the last allowed cycle still times out
   assign timeout_hit_s = (cnt_r >= TO_LAST);

   yarp_lsu_align u_align (
      .st_size   (req_size_s),
      .st_offset (addr_i[1:0]),
      .st_data   (wr_data_i),
      .be        (st_be_s),
      .wdata     (st_wdata_s),
      .ld_size   (size_r),
      .ld_offset (offset_r),
      .ld_zext   (zext_r),
      .rdata     (mem_rdata_i),
      .ld_data   (ld_data_s)
   );

   // next-state and completion-event decode
   always_comb begin
      state_nxt_s    = state_r;
      set_misalign_s = 1'b0;
      set_timeout_s  = 1'b0;
      ld_done_s      = 1'b0;
      case (state_r)
         LSU_IDLE: begin
            if (data_req_i) begin
               if (misalign_s) begin
                  state_nxt_s    = LSU_DONE;
                  set_misalign_s = 1'b1;
               end else begin
                  state_nxt_s = LSU_REQ;
               end
            end else begin
               state_nxt_s = LSU_IDLE;
            end
         end
         LSU_REQ: begin
            if (mem_gnt_i) begin
               state_nxt_s = wr_r ? LSU_DONE : LSU_WAIT_RSP;
            end else if (timeout_hit_s) begin
               state_nxt_s   = LSU_DONE;
               set_timeout_s = 1'b1;
            end else begin
               state_nxt_s = LSU_REQ;
            end
         end
         LSU_WAIT_RSP: begin
            if (mem_rvalid_i) begin
               state_nxt_s = LSU_DONE;
               ld_done_s   = 1'b1;
            end else if (timeout_hit_s) begin
               state_nxt_s   = LSU_DONE;
               set_timeout_s = 1'b1;
            end else begin
               state_nxt_s = LSU_WAIT_RSP;
            end
         end
         LSU_DONE: state_nxt_s = LSU_IDLE;
         default:  state_nxt_s = LSU_IDLE;
      endcase
   end

   // state register and timeout counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= LSU_IDLE;
         cnt_r   <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         if (state_r == LSU_IDLE) begin
            cnt_r <= 8'd0;
         end else if ((state_r == LSU_REQ) || (state_r == LSU_WAIT_RSP)) begin
            cnt_r <= cnt_r + 8'd1;
         end
      end
   end

   // request capture and registered bus outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         size_r      <= MEM_BYTE;
         offset_r    <= 2'b00;
         wr_r        <= 1'b0;
         zext_r      <= 1'b0;
         mem_req_r   <= 1'b0;
         mem_addr_r  <= 32'd0;
         mem_wr_r    <= 1'b0;
         mem_be_r    <= 4'b0000;
         mem_wdata_r <= 32'd0;
      end else begin
         mem_req_r <= (state_nxt_s == LSU_REQ);
         if (capture_s) begin
            size_r      <= req_size_s;
            offset_r    <= addr_i[1:0];
            wr_r        <= data_wr_i;
            zext_r      <= zero_extnd_i;
            mem_addr_r  <= {addr_i[31:2], 2'b00};
            mem_wr_r    <= data_wr_i;
            mem_be_r    <= st_be_s;
            mem_wdata_r <= st_wdata_s;
         end
      end
   end

   // load result and completion pulses, all visible in DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_r  <= 32'd0;
         rd_valid_r <= 1'b0;
         misalign_r <= 1'b0;
         timeout_r  <= 1'b0;
      end else begin
         rd_valid_r <= ld_done_s || (set_timeout_s && !wr_r);
         misalign_r <= set_misalign_s;
         timeout_r  <= set_timeout_s;
         if (ld_done_s) begin
            rd_data_r <= ld_data_s;
         end else if (set_timeout_s && !wr_r) begin
            rd_data_r <= 32'd0;
         end
      end
   end

   assign lsu_busy_o  = capture_s || (state_r == LSU_REQ) || (state_r == LSU_WAIT_RSP);
   assign mem_req_o   = mem_req_r;
   assign mem_addr_o  = mem_addr_r;
   assign mem_wr_o    = mem_wr_r;
   assign mem_be_o    = mem_be_r;
   assign mem_wdata_o = mem_wdata_r;
   assign rd_data_o   = rd_data_r;
   assign rd_valid_o  = rd_valid_r;
   assign misalign_o  = misalign_r;
   assign timeout_o   = timeout_r;

endmodule
